// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: multi-port CDB snooping, up to two in-order commits per cycle.
// Define ROB_PREDICT_STATS_EN to add branch_total_out / branch_miss_out counters.
module reorder_buffer_mc #(
    parameter int TAG_W        = 4,
    parameter int CDB_PORTS    = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid_in,
    output logic                          issue_ready_out,
    output logic [TAG_W-1:0]              issue_tag_out,
    input  logic [6:0]                    issue_opcode_in,
    input  logic [4:0]                    issue_rd_in,
    input  logic [31:0]                   issue_pc_in,
    input  logic [31:0]                   issue_predict_pc_in,
    input  logic [TAG_W-1:0]              qj_tag_in,
    input  logic [TAG_W-1:0]              qk_tag_in,
    output logic                          qj_ready_out,
    output logic                          qk_ready_out,
    output logic [31:0]                   qj_data_out,
    output logic [31:0]                   qk_data_out,
    input  logic [CDB_PORTS-1:0]          cdb_valid_in,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag_in,
    input  logic [CDB_PORTS*32-1:0]       cdb_data_in,
    input  logic [CDB_PORTS*32-1:0]       cdb_new_pc_in,
    output logic [COMMIT_WIDTH-1:0]       commit_valid_out,
    output logic [COMMIT_WIDTH-1:0]       commit_rf_out,
    output logic                          commit_lsb_out,
    output logic [COMMIT_WIDTH*TAG_W-1:0] commit_tag_out,
    output logic [COMMIT_WIDTH*32-1:0]    commit_data_out,
    output logic [COMMIT_WIDTH*5-1:0]     commit_rd_out,
    output logic                          rollback_out,
    output logic [31:0]                   rollback_pc_out,
    output logic [TAG_W:0]                count_out
`ifdef ROB_PREDICT_STATS_EN
    ,
    output logic [31:0]                   branch_total_out,
    output logic [31:0]                   branch_miss_out
`endif
);

    localparam int DEPTH = 1 << TAG_W;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef logic [TAG_W:0]   ptr_t;
    typedef logic [TAG_W-1:0] tag_t;

    ptr_t             head_q, tail_q, count, n_commit;
    tag_t             h0;
    logic [DEPTH-1:0] rdy_q;
    logic [6:0]       op_q   [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      pred_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      npc_q  [DEPTH];

    tag_t       slot_tag [2];
    logic [1:0] slot_st, slot_ok, slot_c;
    logic       ctl0, misp, issue_fire;

    logic [CDB_PORTS-1:0]          cdb_hit;
    logic [32:0]                   qj_l, qk_l;
    logic [COMMIT_WIDTH-1:0]       c_v, c_rf;
    logic                          c_lsb;
    logic [COMMIT_WIDTH*TAG_W-1:0] c_tag;
    logic [COMMIT_WIDTH*32-1:0]    c_data;
    logic [COMMIT_WIDTH*5-1:0]     c_rd;

    assign count           = tail_q - head_q;
    assign h0              = head_q[TAG_W-1:0];
    assign count_out       = count;
    assign issue_tag_out   = tail_q[TAG_W-1:0];
    assign issue_ready_out = rst_n && !rollback_out && (count != ptr_t'(DEPTH));
    assign issue_fire      = issue_valid_in && issue_ready_out;

    // A tag is live when its distance from head is below the occupancy.
    function automatic logic live(input tag_t t);
        tag_t off;
        off = t - h0;
        return {1'b0, off} < count;
    endfunction

    function automatic logic [32:0] lookup(input tag_t t);
        logic [32:0] r;
        r = '0;
        if (live(t)) begin
            if (rdy_q[t]) r = {1'b1, data_q[t]};
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid_in[p] && cdb_tag_in[p*TAG_W +: TAG_W] == t)
                    r = {1'b1, cdb_data_in[p*32 +: 32]};
            end
        end
        return r;
    endfunction

    assign qj_l         = lookup(qj_tag_in);
    assign qk_l         = lookup(qk_tag_in);
    assign qj_ready_out = qj_l[32];
    assign qj_data_out  = qj_l[31:0];
    assign qk_ready_out = qk_l[32];
    assign qk_data_out  = qk_l[31:0];

    always_comb begin
        slot_tag[0] = h0;
        slot_tag[1] = h0 + tag_t'(1);
        for (int s = 0; s < 2; s++) begin
            slot_st[s] = op_q[slot_tag[s]] == OP_STORE;
            slot_ok[s] = rdy_q[slot_tag[s]] || slot_st[s];
        end
        ctl0 = (op_q[h0] == OP_BRANCH) || (op_q[h0] == OP_JALR);
        slot_c[0] = (count != '0) && slot_ok[0];
        slot_c[1] = (COMMIT_WIDTH == 2) && slot_c[0]
                    && (count >= ptr_t'(2)) && slot_ok[1] && !ctl0
                    && !(slot_st[0] && slot_st[1]);
        misp = slot_c[0] && ctl0 && (npc_q[h0] != pred_q[h0]);
        n_commit = ptr_t'(slot_c[0]) + ptr_t'(slot_c[1]);
    end

    // Results for entries retiring on this edge are dropped.
    always_comb begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_hit[p] = cdb_valid_in[p] && !rollback_out
                && live(cdb_tag_in[p*TAG_W +: TAG_W])
                && !(slot_c[0] && cdb_tag_in[p*TAG_W +: TAG_W] == slot_tag[0])
                && !(slot_c[1] && cdb_tag_in[p*TAG_W +: TAG_W] == slot_tag[1]);
        end
    end

    always_comb begin
        c_v    = '0;
        c_rf   = '0;
        c_lsb  = 1'b0;
        c_tag  = '0;
        c_data = '0;
        c_rd   = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            if (slot_c[s]) begin
                c_v[s]  = 1'b1;
                c_rf[s] = !slot_st[s] && (op_q[slot_tag[s]] != OP_BRANCH);
                c_lsb   = c_lsb | slot_st[s];
                c_tag[s*TAG_W +: TAG_W] = slot_tag[s];
                c_data[s*32 +: 32]      = data_q[slot_tag[s]];
                c_rd[s*5 +: 5]          = rd_q[slot_tag[s]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q           <= '0;
            tail_q           <= '0;
            rdy_q            <= '0;
            commit_valid_out <= '0;
            commit_rf_out    <= '0;
            commit_lsb_out   <= 1'b0;
            commit_tag_out   <= '0;
            commit_data_out  <= '0;
            commit_rd_out    <= '0;
            rollback_out     <= 1'b0;
            rollback_pc_out  <= '0;
        end else begin
            commit_valid_out <= c_v;
            commit_rf_out    <= c_rf;
            commit_lsb_out   <= c_lsb;
            commit_tag_out   <= c_tag;
            commit_data_out  <= c_data;
            commit_rd_out    <= c_rd;
            rollback_out     <= misp;
            if (misp) begin
                rollback_pc_out <= npc_q[h0];
                head_q          <= '0;
                tail_q          <= '0;
                rdy_q           <= '0;
            end else begin
                head_q <= head_q + n_commit;
                for (int p = 0; p < CDB_PORTS; p++) begin
                    if (cdb_hit[p])
                        rdy_q[cdb_tag_in[p*TAG_W +: TAG_W]] <= 1'b1;
                end
                if (issue_fire) begin
                    rdy_q[tail_q[TAG_W-1:0]] <= 1'b0;
                    tail_q <= tail_q + ptr_t'(1);
                end
            end
        end
    end

    // Payload needs no reset: nothing is read until the slot is issued.
    always_ff @(posedge clk) begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_hit[p]) begin
                data_q[cdb_tag_in[p*TAG_W +: TAG_W]] <= cdb_data_in[p*32 +: 32];
                npc_q[cdb_tag_in[p*TAG_W +: TAG_W]]  <= cdb_new_pc_in[p*32 +: 32];
            end
        end
        if (issue_fire) begin
            op_q[tail_q[TAG_W-1:0]]   <= issue_opcode_in;
            rd_q[tail_q[TAG_W-1:0]]   <= issue_rd_in;
            pred_q[tail_q[TAG_W-1:0]] <= issue_predict_pc_in;
            data_q[tail_q[TAG_W-1:0]] <= '0;
            npc_q[tail_q[TAG_W-1:0]]  <= '0;
        end
    end

`ifdef ROB_PREDICT_STATS_EN
    logic [1:0]  br_inc, miss_inc;
    logic [32:0] tot_sum, miss_sum;

    always_comb begin
        br_inc   = '0;
        miss_inc = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            if (slot_c[s] && op_q[slot_tag[s]] == OP_BRANCH) begin
                br_inc = br_inc + 2'd1;
                if (npc_q[slot_tag[s]] != pred_q[slot_tag[s]])
                    miss_inc = miss_inc + 2'd1;
            end
        end
        tot_sum  = {1'b0, branch_total_out} + 33'(br_inc);
        miss_sum = {1'b0, branch_miss_out} + 33'(miss_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_total_out <= '0;
            branch_miss_out  <= '0;
        end else begin
            branch_total_out <= tot_sum[32] ? '1 : tot_sum[31:0];
            branch_miss_out  <= miss_sum[32] ? '1 : miss_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/reorder_buffer_mc.md
Name: reorder_buffer_mc

Overview:
Parametrised multi-port, multi-commit successor to the single-CDB, single-commit reorder buffer.
- Circular queue of DEPTH entries holding in-flight instructions between decoder issue and in-order commit.
- Snoops CDB_PORTS result buses and commits up to COMMIT_WIDTH (1 or 2) entries per cycle to RegisterFile/LoadStoreBuffer.
- Raises rollback to Fetcher on JALR/branch mispredict.

Parameters:
TAG_W, 4, tag width; DEPTH = 2**TAG_W entries, all usable (no reserved null slot)
CDB_PORTS, 2, number of snooped broadcast buses (1..4)
COMMIT_WIDTH, 2, max commits per cycle (1 or 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
issue_valid_in  in  1  decoder issues an entry
issue_ready_out  out  1  queue not full and not in rollback cycle
issue_tag_out  out  TAG_W  tag the next issue receives (tail slot)
issue_opcode_in  in  7  inst[6:0]
issue_rd_in  in  5  destination register
issue_pc_in  in  32  instruction pc
issue_predict_pc_in  in  32  predicted next pc
qj_tag_in, qk_tag_in  in  TAG_W each  operand lookup tags
qj_ready_out, qk_ready_out  out  1 each  operand value available
qj_data_out, qk_data_out  out  32 each  operand value
cdb_valid_in  in  CDB_PORTS  per-port broadcast strobe
cdb_tag_in  in  CDB_PORTS*TAG_W  packed tags, port 0 in LSBs
cdb_data_in  in  CDB_PORTS*32  packed results
cdb_new_pc_in  in  CDB_PORTS*32  resolved next pc (JALR/branch only)
commit_valid_out  out  COMMIT_WIDTH  per-slot commit pulse
commit_rf_out  out  COMMIT_WIDTH  slot writes register file
commit_lsb_out  out  1  a store committed this cycle
commit_tag_out  out  COMMIT_WIDTH*TAG_W  committed tags
commit_data_out  out  COMMIT_WIDTH*32  committed values
commit_rd_out  out  COMMIT_WIDTH*5  committed destinations
rollback_out  out  1  one-cycle flush pulse
rollback_pc_out  out  32  redirect pc
count_out  out  TAG_W+1  live entries

Behaviour:
- Reset (rst_n low, async): head = tail = 0, all ready bits 0, every output 0, count_out = 0.
- Pointers are TAG_W+1 bits with a wrap bit.
  - Empty: head == tail.
  - Full: pointers differ only in MSB.
  - Slot index = pointer[TAG_W-1:0]; wrap DEPTH-1 -> 0 is by natural overflow.
- Issue: accepted on posedge when issue_valid_in && issue_ready_out. Writes slot tail with ready = 0; tail advances.
  - issue_ready_out depends only on registered count, so a full queue refuses issue even if a commit happens in the same cycle.
- CDB:
  - A port whose tag is live writes data, new_pc and ready = 1 at the next edge.
  - Non-live tags are ignored.
  - Same tag on multiple ports: highest port index wins.
- Lookup (combinational): ready_out = 1 if the tag is live and either ready, or currently matched by any valid CDB port (bypass; data taken from the winning port). Otherwise ready_out = 0 and data_out is don't-care.
- Commit, decided on registered state; outputs registered (visible the cycle after the deciding edge).
  - Slot 0 = head entry: commits if ready, or if opcode is STORE (0100011).
  - Slot 1 (COMMIT_WIDTH = 2 only) = head+1: commits only if all of:
    - slot 0 commits;
    - count >= 2;
    - entry is ready or a store;
    - slot 0 is not JALR (1100111) or BRANCH (1100011);
    - slot 0 and slot 1 are not both stores.
  - commit_rf_out = opcode not BRANCH and not STORE. commit_lsb_out = any committed slot is a store.
  - A CDB write to an entry being committed the same edge is dropped.
- Rollback:
  - Trigger: slot 0 commits a JALR/BRANCH with new_pc != predict_pc.
  - On that edge: commit outputs are produced normally, rollback_pc_out <= new_pc, rollback_out <= 1, head = tail = 0, all ready cleared.
  - A same-edge issue is discarded; slot-1 commit is already suppressed.
  - During the rollback_out cycle, issue_ready_out = 0 and CDB writes are ignored. rollback_out drops after one cycle.
- Async reset mid-rollback or mid-commit clears everything immediately.

Optional Feature:
ROB_PREDICT_STATS_EN
- Defined: adds outputs branch_total_out (32) and branch_miss_out (32). Each committed BRANCH increments total; each mispredicted BRANCH also increments miss. Counters saturate at 0xFFFFFFFF and clear on reset only, not on rollback.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, issue 16 non-store entries with no CDB -> issue_ready_out = 0 after the 16th, count_out = 16, tail wraps to head with MSB set.
- Issue tags 0,1; CDB port0 tag1 data 0xAA, port1 tag0 data 0x55 in the same cycle -> next cycle both commit together: tags 0,1, data 0x55,0xAA, commit_valid_out = 2'b11.
- Two consecutive stores at head, not ready -> commit one per cycle, commit_lsb_out = 1 each cycle, slot 1 never valid.
- BRANCH tag0 with predict 0x100, CDB new_pc 0x200, younger entry tag1 ready -> only tag0 commits, rollback_out = 1 for one cycle, rollback_pc_out = 0x200, count_out = 0, tag1 never commits.
- Lookup tag 3 while CDB port1 broadcasts tag 3 data 0x1234 -> qj_ready_out = 1, qj_data_out = 0x1234 the same cycle.
- Drop rst_n asynchronously mid-commit with 5 entries live -> all outputs 0 before the next clock edge, count_out = 0.
